pattern_gen_serial: RTL and testbench

- Serial pattern transmitter: the source end of the 1-bit d/valid stream consumed by the overlapping-pattern detector.
- Emits a fixed PAT_LEN-bit pattern MSB-first, repeated a programmable number of times.
- Repeats are either back-to-back or overlapped, sharing an OVERLAP-bit prefix/suffix.
- Used as a stimulus and traffic source on the detector's input, with a ready back-pressure input from the sink.

---
 rtl/pattern_pkg.sv | 19 +
 rtl/pattern_gen_serial.sv | 141 ++++++++++++++
 tb/tb_pattern_gen_serial.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/pattern_pkg.sv
// Shared definitions for the serial pattern source and the overlapping-pattern detector:
// state encodings, symbol constants and the default pattern geometry.
package pattern_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SEND = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic B = 1'b0;
  localparam logic C = 1'b1;

  localparam int                     DEF_PAT_LEN = 5;
  localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = {B, C, C, B, C};
  localparam int                     DEF_OVERLAP = 2;
  localparam int                     DEF_CNT_W   = 8;

endpackage

// File: rtl/pattern_gen_serial.sv
// Serial pattern transmitter: emits PATTERN MSB-first, repeated count_i times, either
// back-to-back or sharing an OVERLAP-bit prefix/suffix, with ready back-pressure.
module pattern_gen_serial
  import pattern_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
  parameter int                 OVERLAP = DEF_OVERLAP,
  parameter int                 CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             overlap_i,
  input  logic             ready_i,
  output logic             d_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] sent_cnt_o
);

  localparam int              IDX_W    = $clog2(PAT_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_LEN - 1);
  localparam logic [IDX_W-1:0] OVL_IDX  = IDX_W'(OVERLAP);

  state_t           r_state, w_state_next;
  logic [IDX_W-1:0] r_idx, w_idx_next;
  logic [CNT_W-1:0] r_remaining, w_remaining_next;
  logic [CNT_W-1:0] r_sent_cnt, w_sent_cnt_next;
  logic             r_overlap, w_overlap_next;
  logic             r_d, w_d_next;
  logic             r_valid, w_valid_next;
  logic             r_done, w_done_next;
  logic             w_xfer;
  logic [IDX_W-1:0] w_reload_idx;

  // Bit-reversed copy so that index 0 addresses the first bit on the wire.
  logic [PAT_LEN-1:0] w_pat_msb_first;
  for (genvar gi = 0; gi < PAT_LEN; gi++) begin : g_rev
    assign w_pat_msb_first[gi] = PATTERN[PAT_LEN-1-gi];
  end

  assign w_xfer       = r_valid && ready_i;
  assign w_reload_idx = r_overlap ? OVL_IDX : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next     = r_state;
    w_idx_next       = r_idx;
    w_remaining_next = r_remaining;
    w_sent_cnt_next  = r_sent_cnt;
    w_overlap_next   = r_overlap;
    w_d_next         = 1'b0;
    w_valid_next     = 1'b0;
    w_done_next      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_sent_cnt_next = '0;
          if (count_i != '0) begin
            w_state_next     = S_SEND;
            w_remaining_next = count_i;
            w_overlap_next   = overlap_i;
            w_idx_next       = '0;
            w_valid_next     = 1'b1;
            w_d_next         = w_pat_msb_first[0];
          end else begin
            w_state_next = S_DONE;
            w_done_next  = 1'b1;
          end
        end
      end

      S_SEND: begin
        // Outputs are precomputed for the next cycle so d_o/valid_o stay registered.
        w_valid_next = 1'b1;
        w_d_next     = r_d;
        if (w_xfer) begin
          if (r_idx != LAST_IDX) begin
            w_idx_next = r_idx + IDX_W'(1);
            w_d_next   = w_pat_msb_first[w_idx_next];
          end else begin
            w_sent_cnt_next  = r_sent_cnt + CNT_W'(1);
            w_remaining_next = r_remaining - CNT_W'(1);
            if (r_remaining == CNT_W'(1)) begin
              w_state_next = S_DONE;
              w_valid_next = 1'b0;
              w_d_next     = 1'b0;
              w_done_next  = 1'b1;
            end else begin
              w_idx_next = w_reload_idx;
              w_d_next   = w_pat_msb_first[w_reload_idx];
            end
          end
        end
      end

      S_DONE: begin
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_remaining <= '0;
      r_sent_cnt  <= '0;
      r_overlap   <= 1'b0;
      r_d         <= 1'b0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_idx       <= w_idx_next;
      r_remaining <= w_remaining_next;
      r_sent_cnt  <= w_sent_cnt_next;
      r_overlap   <= w_overlap_next;
      r_d         <= w_d_next;
      r_valid     <= w_valid_next;
      r_done      <= w_done_next;
    end
  end

  assign d_o        = r_d;
  assign valid_o    = r_valid;
  assign done_o     = r_done;
  assign busy_o     = (r_state == S_SEND) || (r_state == S_DONE);
  assign sent_cnt_o = r_sent_cnt;

endmodule

// File: tb/tb_pattern_gen_serial.sv
// Scoreboard bench for pattern_gen_serial: directed bursts push hand-computed bit
// sequences and done counts; a negedge monitor pops and compares on every transfer.
module tb_pattern_gen_serial;
  import pattern_pkg::*;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_i = 1'b0;
  logic [CNT_W-1:0] count_i = '0;
  logic             overlap_i = 1'b0;
  logic             ready_i = 1'b0;
  logic             d_o, valid_o, busy_o, done_o;
  logic [CNT_W-1:0] sent_cnt_o;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_bits[$];
  int   exp_done[$];
  logic prev_stall = 1'b0;
  logic prev_d     = 1'b0;

  always #5 clk = ~clk;

  pattern_gen_serial dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .count_i   (count_i),
    .overlap_i (overlap_i),
    .ready_i   (ready_i),
    .d_o       (d_o),
    .valid_o   (valid_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .sent_cnt_o(sent_cnt_o)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0d (t=%0t)", name, act, $time);
    end
  endtask

  function automatic logic rdy(input int mode, input int c);
    if (mode == 1) return ((c - 1) % 3 == 0);
    return 1'b1;
  endfunction

  // Monitor: compares every transferred bit, every done pulse and stall stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_d_hold", int'(d_o), int'(prev_d));
        check("stall_valid_hold", int'(valid_o), 1);
      end
      if (valid_o && ready_i) begin
        if (exp_bits.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_bit: got d_o=%0d, expected no transfer (t=%0t)", d_o, $time);
        end else begin
          check("bit", int'(d_o), int'(exp_bits.pop_front()));
        end
      end
      if (done_o) begin
        if (exp_done.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done_o=1, expected 0 (t=%0t)", $time);
        end else begin
          check("sent_cnt_at_done", int'(sent_cnt_o), exp_done.pop_front());
        end
        check("valid_low_at_done", int'(valid_o), 0);
      end
      prev_stall = valid_o && !ready_i;
      prev_d     = d_o;
    end
  end

  task automatic run_burst(input int cnt, input logic ovl, input int mode,
                           input logic [31:0] vec, input int nbits,
                           input int done_cyc, input logic pulse_start);
    int at;
    for (int i = nbits - 1; i >= 0; i--) exp_bits.push_back(vec[i]);
    exp_done.push_back(cnt);
    @(posedge clk); #1;
    start_i   = 1'b1;
    count_i   = CNT_W'(cnt);
    overlap_i = ovl;
    ready_i   = rdy(mode, 0);
    @(posedge clk); #1;
    start_i   = 1'b0;
    count_i   = 8'd7;
    overlap_i = ~ovl;
    at = 0;
    for (int c = 1; c < 300; c++) begin
      ready_i = rdy(mode, c);
      start_i = pulse_start && (c == 3);
      @(negedge clk);
      check("busy_in_burst", int'(busy_o), 1);
      if (done_o) begin
        at = c;
        break;
      end
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    if (at == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done_o within 300 cycles, expected a pulse");
    end else if (done_cyc > 0) begin
      check("done_cycle", at, done_cyc);
    end
    check("bits_outstanding", exp_bits.size(), 0);
    @(negedge clk);
    check("done_single_pulse", int'(done_o), 0);
    check("busy_after_burst", int'(busy_o), 0);
    check("sent_cnt_hold", int'(sent_cnt_o), cnt);
  endtask

  initial begin
    #12;
    check("rst_valid", int'(valid_o), 0);
    check("rst_d", int'(d_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_sent_cnt", int'(sent_cnt_o), 0);
    @(negedge clk);
    rst = 1'b0;

    run_burst(1, 1'b0, 0, 32'b01101, 5, 6, 1'b0);
    run_burst(3, 1'b1, 0, 32'b01101101101, 11, 12, 1'b0);
    run_burst(3, 1'b0, 0, 32'b011010110101101, 15, 16, 1'b1);
    run_burst(2, 1'b1, 1, 32'b01101101, 8, 0, 1'b0);
    run_burst(0, 1'b0, 0, 32'b0, 0, 1, 1'b0);

    // Asynchronous reset after the third transferred bit of a two-instance burst.
    exp_bits.push_back(1'b0);
    exp_bits.push_back(1'b1);
    exp_bits.push_back(1'b1);
    @(posedge clk); #1;
    start_i   = 1'b1;
    count_i   = 8'd2;
    overlap_i = 1'b0;
    ready_i   = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_valid", int'(valid_o), 1);
    check("pre_rst_busy", int'(busy_o), 1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_valid", int'(valid_o), 0);
    check("async_rst_d", int'(d_o), 0);
    check("async_rst_busy", int'(busy_o), 0);
    check("async_rst_sent_cnt", int'(sent_cnt_o), 0);
    check("async_rst_bits_left", exp_bits.size(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    run_burst(1, 1'b0, 0, 32'b01101, 5, 6, 1'b0);

    check("done_queue_empty", exp_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
